traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Actuated, multi-approach intersection scheduler: decides which approach of an N-way junction receives green.
- Drives per-approach red/yellow/green lamps through GREEN -> YELLOW -> ALL-RED -> SELECT phases.
- Round-robin fairness over vehicle sensors, min/max green timing and emergency-vehicle preemption.
- Sits above the per-road lamp drivers and replaces fixed two-road sequencing at junctions with more than two approaches.

Parameters:
- N_APPR, 4, number of approaches (2..8).
- MIN_GREEN, 4, minimum green cycles before a gap-out.
- MAX_GREEN, 12, maximum green cycles while another approach waits.
- YEL_HOLD, 3, yellow cycles.
- ALLRED_HOLD, 2, all-red clearance cycles.
- CNT_W, 8, phase counter width; every HOLD/GREEN value must be < 2^CNT_W.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_APPR  level vehicle-present sensor per approach.
- emerg_valid  in  1  level emergency preemption request.
- emerg_id  in  clog2(N_APPR)  approach the emergency vehicle needs.
- lights  out  3*N_APPR  per approach i, bits [3i+2:3i]: 100 red, 010 yellow, 001 green.
- active_id  out  clog2(N_APPR)  approach currently or most recently granted.
- grant_pulse  out  1  high for one cycle, in the first GREEN cycle of each grant.
- busy  out  1  high in every state except GREEN.

Behaviour:
- Reset (async, immediate, including mid-phase):
  - state=ALLRED, counter=0, active_id=0.
  - All lights=100, grant_pulse=0, busy=1.
- Counter:
  - Clears to 0 on every state change, otherwise increments.
  - Saturates at MAX_GREEN-1 in GREEN.
- Timed states last exactly their HOLD count: exit when counter==HOLD-1.
- Outputs are Moore, derived combinationally from the registered state, active_id and counter.
  - GREEN: approach active_id=001.
  - YELLOW: approach active_id=010.
  - All other approaches, and every approach in ALLRED and SELECT: 100.
  - Exactly one approach may be non-red at any time.
- ALLRED: after ALLRED_HOLD cycles -> SELECT.
- SELECT: lasts 1 cycle, all red. Registers the new active_id, then -> GREEN. Priority:
  1. emerg_valid and emerg_id<N_APPR -> emerg_id.
  2. Else round-robin: first set req bit searching active_id+1, active_id+2, ... wrapping, with active_id itself checked last.
  3. Else approach 0 (home approach rests in green).
- GREEN: let other = req with bit active_id masked off; emg_other = emerg_valid && emerg_id!=active_id && emerg_id<N_APPR.
  - emg_other -> YELLOW next cycle, regardless of counter (MIN_GREEN bypassed).
  - Else emerg_valid && emerg_id==active_id -> hold GREEN indefinitely, even past MAX.
  - Else counter>=MIN_GREEN-1 && other!=0 && req[active_id]==0 (gap-out) -> YELLOW.
  - Else counter==MAX_GREEN-1 && other!=0 (max-out) -> YELLOW.
  - Else stay; with no other request, green rests indefinitely.
- YELLOW: always runs the full YEL_HOLD, then ALLRED. Emergency or req changes do not shorten yellow or all-red.
- emerg_id>=N_APPR is ignored as if emerg_valid=0.
- Inputs are sampled only on clock edges; emergency requests are not latched, so the requester holds emerg_valid until it sees green.
- Simultaneous emergency and gap-out/max-out in the same cycle: single YELLOW entry; the emergency approach wins the following SELECT.

Test Plan:
- Reset release, req=0:
  - ALLRED for cycles 0-1, SELECT at cycle 2.
  - Approach 0 green from cycle 3 with grant_pulse=1, then rests green.
  - busy=1 for cycles 0-2, 0 from cycle 3.
- Round robin: approach 0 green, req=4'b1010 held:
  - Max-out at MAX_GREEN, then yellow 3, all-red 2.
  - Approach 1 green, then approach 3, then approach 1.
  - Approach 2 never green.
- Gap-out: approach 1 green, req[1]=1 and req[2]=1:
  - Drop req[1] at green cycle 1: YELLOW entered after green cycle 3 (MIN_GREEN=4).
  - Drop req[1] at green cycle 6: YELLOW on the next cycle.
- Preemption: approach 0 green at counter=1, emerg_valid=1, emerg_id=3:
  - YELLOW next cycle, 3 yellow + 2 all-red cycles.
  - Approach 3 green; stays green past 12 cycles while emerg held, even with req=4'b0111.
- Invalid emergency: emerg_id=5 with N_APPR=4 -> no preemption; normal round robin.
- Mid-phase reset: assert rst during YELLOW -> lights all 100 immediately, without waiting for a clock edge; after release, the reset timeline repeats.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler
// Purpose  : Actuated N-approach junction scheduler. Cycles the granted
//            approach through GREEN -> YELLOW -> ALL-RED -> SELECT. It picks
//            the next approach by round-robin over the vehicle sensors, applies
//            min/max green timing and honours emergency preemption.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int N_APPR      = 4,
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 12,
    parameter int YEL_HOLD    = 3,
    parameter int ALLRED_HOLD = 2,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_APPR-1:0]         req,
    input  logic                      emerg_valid,
    input  logic [$clog2(N_APPR)-1:0] emerg_id,
    output logic [3*N_APPR-1:0]       lights,
    output logic [$clog2(N_APPR)-1:0] active_id,
    output logic                      grant_pulse,
    output logic                      busy
);

    localparam int ID_W = $clog2(N_APPR);

    localparam logic [1:0] c_st_allred = 2'd0;
    localparam logic [1:0] c_st_select = 2'd1;
    localparam logic [1:0] c_st_green  = 2'd2;
    localparam logic [1:0] c_st_yellow = 2'd3;

    // Last counter value of each timed phase.
    localparam logic [CNT_W-1:0] c_min_last = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_max_last = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yel_last = CNT_W'(YEL_HOLD - 1);
    localparam logic [CNT_W-1:0] c_ar_last  = CNT_W'(ALLRED_HOLD - 1);

    // One bit wider than the id so that out-of-range ids can be recognised
    // even when N_APPR is a power of two.
    localparam logic [ID_W:0] c_n_appr = (ID_W + 1)'(N_APPR);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]   r_active;
    logic [ID_W-1:0]   w_active_nxt;

    logic              w_emg_ok;
    logic              w_emg_other;
    logic              w_emg_self;
    logic [N_APPR-1:0] w_self_mask;
    logic [N_APPR-1:0] w_other_req;
    logic              w_gap_out;
    logic              w_max_out;
    logic              w_rr_found;
    logic [ID_W-1:0]   w_rr_id;
    logic [ID_W-1:0]   w_rr_idx;

    // Emergency qualification and green-phase termination conditions.
    always_comb begin
        w_self_mask           = '0;
        w_self_mask[r_active] = 1'b1;
        w_other_req           = req & ~w_self_mask;
        w_emg_ok              = emerg_valid && ({1'b0, emerg_id} < c_n_appr);
        w_emg_other           = w_emg_ok && (emerg_id != r_active);
        w_emg_self            = w_emg_ok && (emerg_id == r_active);
        w_gap_out             = (r_cnt >= c_min_last) && (w_other_req != '0) && !req[r_active];
        w_max_out             = (r_cnt == c_max_last) && (w_other_req != '0);
    end

    // Round-robin search starting just after the current approach; the
    // current approach itself is visited last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        w_rr_idx   = '0;
        for (int k = 1; k <= N_APPR; k++) begin
            w_rr_idx = ID_W'((int'(r_active) + k) % N_APPR);
            if (!w_rr_found && req[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_rr_id    = w_rr_idx;
            end
        end
    end

    // Next-state and next-grant selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        case (r_state)
            c_st_allred: begin
                if (r_cnt == c_ar_last) w_state_nxt = c_st_select;
            end
            c_st_select: begin
                w_state_nxt = c_st_green;
                if (w_emg_ok)        w_active_nxt = emerg_id;
                else if (w_rr_found) w_active_nxt = w_rr_id;
                else                 w_active_nxt = '0;
            end
            c_st_green: begin
                if (w_emg_other)                 w_state_nxt = c_st_yellow;
                else if (w_emg_self)             w_state_nxt = c_st_green;
                else if (w_gap_out || w_max_out) w_state_nxt = c_st_yellow;
            end
            c_st_yellow: begin
                if (r_cnt == c_yel_last) w_state_nxt = c_st_allred;
            end
            default: w_state_nxt = c_st_allred;
        endcase
    end

    // State, grant and phase counter registers; the counter restarts on every
    // phase change and parks at MAX_GREEN-1 while green rests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_allred;
            r_cnt    <= '0;
            r_active <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == c_st_green) && (r_cnt >= c_max_last)) begin
                r_cnt <= c_max_last;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Moore lamp decode: only the granted approach can leave red. The grant
    // pulse relies on MAX_GREEN >= 2 so a resting counter never returns to 0.
    always_comb begin
        lights = '0;
        for (int i = 0; i < N_APPR; i++) begin
            lights[3*i +: 3] = 3'b100;
            if (ID_W'(i) == r_active) begin
                if (r_state == c_st_green)       lights[3*i +: 3] = 3'b001;
                else if (r_state == c_st_yellow) lights[3*i +: 3] = 3'b010;
            end
        end
        active_id   = r_active;
        grant_pulse = (r_state == c_st_green) && (r_cnt == '0);
        busy        = (r_state != c_st_green);
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Purpose  : Self-checking bench for traffic_phase_scheduler. A table of
//            {inputs, cycles to advance, expected outputs} records drives a
//            4-approach instance; a 5-approach instance covers out-of-range
//            emergency ids.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        emerg_valid;
    logic [1:0]  emerg_id;
    logic [11:0] lights;
    logic [1:0]  active_id;
    logic        grant_pulse;
    logic        busy;

    logic [4:0]  req5;
    logic        emerg_valid5;
    logic [2:0]  emerg_id5;
    logic [14:0] lights5;
    logic [2:0]  active_id5;
    logic        grant_pulse5;
    logic        busy5;

    int n_checks = 0;
    int n_errors = 0;

    traffic_phase_scheduler u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .emerg_valid (emerg_valid),
        .emerg_id    (emerg_id),
        .lights      (lights),
        .active_id   (active_id),
        .grant_pulse (grant_pulse),
        .busy        (busy)
    );

    traffic_phase_scheduler #(.N_APPR(5)) u_dut5 (
        .clk         (clk),
        .rst         (rst),
        .req         (req5),
        .emerg_valid (emerg_valid5),
        .emerg_id    (emerg_id5),
        .lights      (lights5),
        .active_id   (active_id5),
        .grant_pulse (grant_pulse5),
        .busy        (busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        ev;
        logic [1:0]  eid;
        int          adv;
        logic [11:0] lights;
        logic [1:0]  act;
        logic        grant;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [11:0] lights;
        logic [1:0]  act;
        logic        grant;
        logic        busy;
        int          idx;
    } exp_t;

    vec_t vecs[34];
    exp_t sb[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Each lamp field must be a legal code and at most one may be non-red.
    function automatic logic lamps_legal(input logic [11:0] l);
        int non_red = 0;
        logic ok = 1'b1;
        for (int a = 0; a < 4; a++) begin
            logic [2:0] f;
            f = l[3*a +: 3];
            if (f != 3'b100) non_red++;
            if (f != 3'b100 && f != 3'b010 && f != 3'b001) ok = 1'b0;
        end
        return ok && (non_red <= 1);
    endfunction

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            check("lamp_legal", c, 32'(lamps_legal(lights)), 32'd1);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            req         = vecs[i].req;
            emerg_valid = vecs[i].ev;
            emerg_id    = vecs[i].eid;
            e.lights = vecs[i].lights;
            e.act    = vecs[i].act;
            e.grant  = vecs[i].grant;
            e.busy   = vecs[i].busy;
            e.idx    = i;
            sb.push_back(e);
            step(vecs[i].adv);
            e = sb.pop_front();
            check("lights",      e.idx, 32'(lights),      32'(e.lights));
            check("active_id",   e.idx, 32'(active_id),   32'(e.act));
            check("grant_pulse", e.idx, 32'(grant_pulse), 32'(e.grant));
            check("busy",        e.idx, 32'(busy),        32'(e.busy));
        end
    endtask

    initial begin
        // Reset release with no demand: cycles 0-1 all-red, 2 select, 3 green 0.
        vecs[0]  = '{4'b0000, 1'b0, 2'd0, 0,  12'h924, 2'd0, 1'b0, 1'b1};
        vecs[1]  = '{4'b0000, 1'b0, 2'd0, 1,  12'h924, 2'd0, 1'b0, 1'b1};
        vecs[2]  = '{4'b0000, 1'b0, 2'd0, 1,  12'h924, 2'd0, 1'b0, 1'b1};
        vecs[3]  = '{4'b0000, 1'b0, 2'd0, 1,  12'h921, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0000, 1'b0, 2'd0, 1,  12'h921, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 1'b0, 2'd0, 20, 12'h921, 2'd0, 1'b0, 1'b0};
        // Round robin with req=1010: 0 -> 1 -> 3 -> 1, max-out on 1 and 3.
        vecs[6]  = '{4'b1010, 1'b0, 2'd0, 1,  12'h922, 2'd0, 1'b0, 1'b1};
        vecs[7]  = '{4'b1010, 1'b0, 2'd0, 2,  12'h922, 2'd0, 1'b0, 1'b1};
        vecs[8]  = '{4'b1010, 1'b0, 2'd0, 1,  12'h924, 2'd0, 1'b0, 1'b1};
        vecs[9]  = '{4'b1010, 1'b0, 2'd0, 2,  12'h924, 2'd0, 1'b0, 1'b1};
        vecs[10] = '{4'b1010, 1'b0, 2'd0, 1,  12'h90C, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{4'b1010, 1'b0, 2'd0, 11, 12'h90C, 2'd1, 1'b0, 1'b0};
        vecs[12] = '{4'b1010, 1'b0, 2'd0, 1,  12'h914, 2'd1, 1'b0, 1'b1};
        vecs[13] = '{4'b1010, 1'b0, 2'd0, 6,  12'h324, 2'd3, 1'b1, 1'b0};
        vecs[14] = '{4'b1010, 1'b0, 2'd0, 18, 12'h90C, 2'd1, 1'b1, 1'b0};
        // Gap-out: early drop waits for MIN_GREEN, late drop ends next cycle.
        vecs[15] = '{4'b0110, 1'b0, 2'd0, 1,  12'h90C, 2'd1, 1'b0, 1'b0};
        vecs[16] = '{4'b0100, 1'b0, 2'd0, 2,  12'h90C, 2'd1, 1'b0, 1'b0};
        vecs[17] = '{4'b0100, 1'b0, 2'd0, 1,  12'h914, 2'd1, 1'b0, 1'b1};
        vecs[18] = '{4'b0100, 1'b0, 2'd0, 6,  12'h864, 2'd2, 1'b1, 1'b0};
        vecs[19] = '{4'b0110, 1'b0, 2'd0, 6,  12'h864, 2'd2, 1'b0, 1'b0};
        vecs[20] = '{4'b0010, 1'b0, 2'd0, 1,  12'h8A4, 2'd2, 1'b0, 1'b1};
        vecs[21] = '{4'b0010, 1'b0, 2'd0, 6,  12'h90C, 2'd1, 1'b1, 1'b0};
        // Bring approach 0 to green, then preempt to approach 3 at counter 1.
        vecs[22] = '{4'b0001, 1'b0, 2'd0, 3,  12'h90C, 2'd1, 1'b0, 1'b0};
        vecs[23] = '{4'b0001, 1'b0, 2'd0, 1,  12'h914, 2'd1, 1'b0, 1'b1};
        vecs[24] = '{4'b0001, 1'b0, 2'd0, 6,  12'h921, 2'd0, 1'b1, 1'b0};
        vecs[25] = '{4'b0001, 1'b0, 2'd0, 1,  12'h921, 2'd0, 1'b0, 1'b0};
        vecs[26] = '{4'b0001, 1'b1, 2'd3, 1,  12'h922, 2'd0, 1'b0, 1'b1};
        vecs[27] = '{4'b0001, 1'b1, 2'd3, 4,  12'h924, 2'd0, 1'b0, 1'b1};
        vecs[28] = '{4'b0001, 1'b1, 2'd3, 1,  12'h924, 2'd0, 1'b0, 1'b1};
        vecs[29] = '{4'b0001, 1'b1, 2'd3, 1,  12'h324, 2'd3, 1'b1, 1'b0};
        vecs[30] = '{4'b0111, 1'b1, 2'd3, 20, 12'h324, 2'd3, 1'b0, 1'b0};
        vecs[31] = '{4'b0111, 1'b0, 2'd3, 1,  12'h524, 2'd3, 1'b0, 1'b1};
        // Emergency coinciding with gap/max-out: one yellow, emergency wins.
        vecs[32] = '{4'b0010, 1'b1, 2'd2, 1,  12'h922, 2'd0, 1'b0, 1'b1};
        vecs[33] = '{4'b0010, 1'b1, 2'd2, 6,  12'h864, 2'd2, 1'b1, 1'b0};

        rst          = 1'b1;
        req          = '0;
        emerg_valid  = 1'b0;
        emerg_id     = '0;
        req5         = 5'b00010;
        emerg_valid5 = 1'b1;
        emerg_id5    = 3'd5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_range(0, 3);
        // Out-of-range emergency id must be ignored: approach 1 wins by round robin.
        check("inv_emg_lights", 3, 32'(lights5),      32'h490C);
        check("inv_emg_grant",  3, 32'(grant_pulse5), 32'd1);
        run_range(4, 5);
        check("inv_emg_lights", 5, 32'(lights5),      32'h490C);
        check("inv_emg_active", 5, 32'(active_id5),   32'd1);
        check("inv_emg_busy",   5, 32'(busy5),        32'd0);

        run_range(6, 31);

        // Asynchronous reset during yellow: lamps go red without a clock edge.
        rst = 1'b1;
        #2;
        check("async_rst_lights", 100, 32'(lights),      32'h924);
        check("async_rst_active", 100, 32'(active_id),   32'd0);
        check("async_rst_grant",  100, 32'(grant_pulse), 32'd0);
        check("async_rst_busy",   100, 32'(busy),        32'd1);
        req         = '0;
        emerg_valid = 1'b0;
        emerg_id    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_range(0, 5);
        run_range(32, 33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
